// File: rtl/irq_pkg.sv
// Shared types and default constants for the CP0 interrupt source requester.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } ch_state_e;

  localparam int IRQ_NCH             = 3;
  localparam int IRQ_CNT_W           = 4;
  localparam int IRQ_GAP_CYCLES      = 2;
  localparam int IRQ_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/irq_channel.sv
// One interrupt channel: sync, optional debounce (IRQ_DEBOUNCE_EN),
// edge detect, pending counter and request FSM.
module irq_channel
  import irq_pkg::*;
#(
  parameter int CNT_W           = IRQ_CNT_W,
  parameter int GAP_CYCLES      = IRQ_GAP_CYCLES,
  parameter int DEBOUNCE_CYCLES = IRQ_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_raw,
  input  logic             ack,
  output logic             irq,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
  logic f, evt, ack_acc, go;
  logic ovf_q, ovf_d, irq_q, irq_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [GW-1:0] gap_q, gap_d;
  ch_state_e state_q, state_d;

`ifdef IRQ_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic f_q, f_d;
  logic [DB_W-1:0] db_q, db_d;

  // f flips only once s2 has disagreed for DEBOUNCE_CYCLES cycles
  always_comb begin
    f_d  = f_q;
    db_d = '0;
    if (s2_q != f_q) begin
      if (db_q == DB_LAST) f_d = s2_q;
      else db_d = db_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q  <= 1'b0;
      db_q <= '0;
    end else begin
      f_q  <= f_d;
      db_q <= db_d;
    end
  end

  assign f = f_q;
`else
  logic unused_db;
  assign unused_db = (DEBOUNCE_CYCLES > 0);
  assign f = s2_q;
`endif

  always_comb begin
    s1_d    = req_raw;
    s2_d    = s1_q;
    prev_d  = f;
    evt     = f & ~prev_q;
    ack_acc = ack && (state_q == ASSERT);
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    if (evt && !ack_acc) begin
      if (pend_q == CNT_MAX) ovf_d = 1'b1;
      else pend_d = pend_q + 1'b1;
    end else if (!evt && ack_acc && pend_q != '0) begin
      pend_d = pend_q - 1'b1;
    end
    go      = evt || (pend_q != '0);
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE:   if (go) state_d = ASSERT;
      ASSERT: if (ack) begin
        state_d = GAP;
        gap_d   = '0;
      end
      // last gap cycle hands straight to the next request
      GAP:    if (gap_q == GAP_LAST) state_d = go ? ASSERT : IDLE;
              else gap_d = gap_q + 1'b1;
      default: state_d = IDLE;
    endcase
    irq_d = (state_d == ASSERT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      gap_q   <= '0;
      state_q <= IDLE;
      irq_q   <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      prev_q  <= prev_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      gap_q   <= gap_d;
      state_q <= state_d;
      irq_q   <= irq_d;
    end
  end

  assign irq      = irq_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/irq_source_ctrl.sv
// Drives the CP0 intsrc lines from NCH independent request channels.
// Define IRQ_DEBOUNCE_EN to add a debounce filter on every channel.
module irq_source_ctrl
  import irq_pkg::*;
#(
  parameter int NCH             = IRQ_NCH,
  parameter int CNT_W           = IRQ_CNT_W,
  parameter int GAP_CYCLES      = IRQ_GAP_CYCLES,
  parameter int DEBOUNCE_CYCLES = IRQ_DEBOUNCE_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       req_raw,
  input  logic [NCH-1:0]       ack,
  output logic [NCH-1:0]       irq,
  output logic [NCH*CNT_W-1:0] pending,
  output logic [NCH-1:0]       overflow
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    irq_channel #(
      .CNT_W          (CNT_W),
      .GAP_CYCLES     (GAP_CYCLES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .req_raw (req_raw[i]),
      .ack     (ack[i]),
      .irq     (irq[i]),
      .pending (pending[i*CNT_W +: CNT_W]),
      .overflow(overflow[i])
    );
  end

endmodule

// File: tb/tb_irq_source_ctrl.sv
// Scoreboard bench for irq_source_ctrl.
module tb_irq_source_ctrl;

  localparam int NCH   = 3;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NCH-1:0] req_raw = '0;
  logic [NCH-1:0] ack = '0;
  logic [NCH-1:0] irq;
  logic [NCH*CNT_W-1:0] pending;
  logic [NCH-1:0] overflow;

  irq_source_ctrl #(
    .NCH(NCH), .CNT_W(CNT_W), .GAP_CYCLES(2), .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .req_raw(req_raw), .ack(ack),
    .irq(irq), .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    t;
    int    ch;
    logic  irq;
    int    pend;
    logic  ovf;
    string tag;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int base = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic expect_at(int t, int ch, logic i, int p, logic o, string tag);
    sbq.push_back('{base + t, ch, i, p, o, tag});
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    base = cyc;
    for (int c = 0; c < NCH; c++) expect_at(1, c, 1'b0, 0, 1'b0, "reset");
    tick();
    while (sbq.size() > 0 && sbq[0].t <= cyc) begin
      e = sbq.pop_front();
      total++;
      if (irq[e.ch] !== e.irq || pending[e.ch*CNT_W +: CNT_W] !== CNT_W'(e.pend)
          || overflow[e.ch] !== e.ovf) begin
        bad++;
        $display("FAIL %s ch%0d: got irq=%b pend=%0d ovf=%b, want irq=%b pend=%0d ovf=%b",
          e.tag, e.ch, irq[e.ch], pending[e.ch*CNT_W +: CNT_W], overflow[e.ch],
          e.irq, e.pend, e.ovf);
      end
    end
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); total++; bad++;
      $display("FAIL %s never reached", e.tag);
    end
  endtask

  task automatic test_single();
    exp_t e;
    int t;
    base = cyc;
    expect_at(2, 0, 1'b0, 0, 1'b0, "single_pre");
    expect_at(3, 0, 1'b1, 1, 1'b0, "single_rise");
    expect_at(5, 0, 1'b1, 1, 1'b0, "single_hold");
    expect_at(6, 0, 1'b0, 0, 1'b0, "single_ack");
    expect_at(7, 0, 1'b0, 0, 1'b0, "single_gap");
    expect_at(10, 0, 1'b0, 0, 1'b0, "single_idle");
    req_raw[0] = 1'b1;
    repeat (10) begin
      tick();
      t = cyc - base;
      while (sbq.size() > 0 && sbq[0].t <= cyc) begin
        e = sbq.pop_front();
        total++;
        if (irq[e.ch] !== e.irq || pending[e.ch*CNT_W +: CNT_W] !== CNT_W'(e.pend)
            || overflow[e.ch] !== e.ovf) begin
          bad++;
          $display("FAIL %s ch%0d: got irq=%b pend=%0d ovf=%b, want irq=%b pend=%0d ovf=%b",
            e.tag, e.ch, irq[e.ch], pending[e.ch*CNT_W +: CNT_W], overflow[e.ch],
            e.irq, e.pend, e.ovf);
        end
      end
      ack[0] = (t == 5);
      if (t == 8) req_raw[0] = 1'b0;
    end
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); total++; bad++;
      $display("FAIL %s never reached", e.tag);
    end
  endtask

  task automatic test_multi();
    exp_t e;
    int t;
    base = cyc;
    expect_at(3, 1, 1'b1, 1, 1'b0, "multi_p1");
    expect_at(11, 1, 1'b1, 2, 1'b0, "multi_p2");
    expect_at(19, 1, 1'b1, 3, 1'b0, "multi_p3");
    expect_at(23, 1, 1'b0, 2, 1'b0, "multi_ack1");
    expect_at(24, 1, 1'b0, 2, 1'b0, "multi_gap1");
    expect_at(25, 1, 1'b1, 2, 1'b0, "multi_re1");
    expect_at(28, 1, 1'b0, 1, 1'b0, "multi_ack2");
    expect_at(29, 1, 1'b0, 1, 1'b0, "multi_gap2");
    expect_at(30, 1, 1'b1, 1, 1'b0, "multi_re2");
    expect_at(33, 1, 1'b0, 0, 1'b0, "multi_ack3");
    expect_at(35, 1, 1'b0, 0, 1'b0, "multi_stay");
    expect_at(37, 1, 1'b0, 0, 1'b0, "multi_idle");
    req_raw[1] = 1'b1;
    repeat (37) begin
      tick();
      t = cyc - base;
      while (sbq.size() > 0 && sbq[0].t <= cyc) begin
        e = sbq.pop_front();
        total++;
        if (irq[e.ch] !== e.irq || pending[e.ch*CNT_W +: CNT_W] !== CNT_W'(e.pend)
            || overflow[e.ch] !== e.ovf) begin
          bad++;
          $display("FAIL %s ch%0d: got irq=%b pend=%0d ovf=%b, want irq=%b pend=%0d ovf=%b",
            e.tag, e.ch, irq[e.ch], pending[e.ch*CNT_W +: CNT_W], overflow[e.ch],
            e.irq, e.pend, e.ovf);
        end
      end
      req_raw[1] = (t < 20) && ((t / 4) % 2 == 0);
      ack[1] = (t == 22) || (t == 27) || (t == 32);
    end
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); total++; bad++;
      $display("FAIL %s never reached", e.tag);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int t;
    base = cyc;
    expect_at(3, 2, 1'b1, 1, 1'b0, "b2b_rise");
    expect_at(8, 2, 1'b1, 1, 1'b0, "b2b_pre");
    expect_at(9, 2, 1'b0, 1, 1'b0, "b2b_same");
    expect_at(10, 2, 1'b0, 1, 1'b0, "b2b_gap");
    expect_at(11, 2, 1'b1, 1, 1'b0, "b2b_re");
    expect_at(13, 2, 1'b0, 0, 1'b0, "b2b_ack");
    expect_at(16, 2, 1'b0, 0, 1'b0, "b2b_idle");
    req_raw[2] = 1'b1;
    repeat (16) begin
      tick();
      t = cyc - base;
      while (sbq.size() > 0 && sbq[0].t <= cyc) begin
        e = sbq.pop_front();
        total++;
        if (irq[e.ch] !== e.irq || pending[e.ch*CNT_W +: CNT_W] !== CNT_W'(e.pend)
            || overflow[e.ch] !== e.ovf) begin
          bad++;
          $display("FAIL %s ch%0d: got irq=%b pend=%0d ovf=%b, want irq=%b pend=%0d ovf=%b",
            e.tag, e.ch, irq[e.ch], pending[e.ch*CNT_W +: CNT_W], overflow[e.ch],
            e.irq, e.pend, e.ovf);
        end
      end
      req_raw[2] = (t < 4) || (t >= 6 && t < 10);
      ack[2] = (t == 8) || (t == 12);
    end
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); total++; bad++;
      $display("FAIL %s never reached", e.tag);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    int t;
    base = cyc;
    expect_at(31, 0, 1'b1, 15, 1'b0, "sat_full");
    expect_at(33, 0, 1'b1, 15, 1'b1, "sat_ovf");
    expect_at(36, 0, 1'b0, 14, 1'b1, "sat_ack1");
    expect_at(38, 0, 1'b1, 14, 1'b1, "sat_re1");
    expect_at(78, 0, 1'b0, 0, 1'b1, "sat_drained");
    expect_at(82, 0, 1'b0, 0, 1'b1, "sat_sticky");
    req_raw[0] = 1'b1;
    repeat (82) begin
      tick();
      t = cyc - base;
      while (sbq.size() > 0 && sbq[0].t <= cyc) begin
        e = sbq.pop_front();
        total++;
        if (irq[e.ch] !== e.irq || pending[e.ch*CNT_W +: CNT_W] !== CNT_W'(e.pend)
            || overflow[e.ch] !== e.ovf) begin
          bad++;
          $display("FAIL %s ch%0d: got irq=%b pend=%0d ovf=%b, want irq=%b pend=%0d ovf=%b",
            e.tag, e.ch, irq[e.ch], pending[e.ch*CNT_W +: CNT_W], overflow[e.ch],
            e.irq, e.pend, e.ovf);
        end
      end
      req_raw[0] = (t < 32) && (t % 2 == 0);
      ack[0] = (t >= 35) && (t <= 77) && ((t - 35) % 3 == 0);
    end
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); total++; bad++;
      $display("FAIL %s never reached", e.tag);
    end
  endtask

  task automatic test_spurious();
    exp_t e;
    int t;
    base = cyc;
    expect_at(1, 1, 1'b0, 0, 1'b0, "spur_ack");
    expect_at(3, 1, 1'b0, 0, 1'b0, "spur_after");
    ack[1] = 1'b1;
    repeat (3) begin
      tick();
      t = cyc - base;
      while (sbq.size() > 0 && sbq[0].t <= cyc) begin
        e = sbq.pop_front();
        total++;
        if (irq[e.ch] !== e.irq || pending[e.ch*CNT_W +: CNT_W] !== CNT_W'(e.pend)
            || overflow[e.ch] !== e.ovf) begin
          bad++;
          $display("FAIL %s ch%0d: got irq=%b pend=%0d ovf=%b, want irq=%b pend=%0d ovf=%b",
            e.tag, e.ch, irq[e.ch], pending[e.ch*CNT_W +: CNT_W], overflow[e.ch],
            e.irq, e.pend, e.ovf);
        end
      end
      ack[1] = 1'b0;
    end
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); total++; bad++;
      $display("FAIL %s never reached", e.tag);
    end
  endtask

  task automatic test_rst_mid();
    exp_t e;
    int t;
    base = cyc;
    expect_at(6, 0, 1'b1, 2, 1'b1, "rst_pre");
    expect_at(7, 0, 1'b0, 0, 1'b0, "rst_edge");
    expect_at(9, 0, 1'b0, 0, 1'b0, "rst_after");
    req_raw[0] = 1'b1;
    repeat (9) begin
      tick();
      t = cyc - base;
      while (sbq.size() > 0 && sbq[0].t <= cyc) begin
        e = sbq.pop_front();
        total++;
        if (irq[e.ch] !== e.irq || pending[e.ch*CNT_W +: CNT_W] !== CNT_W'(e.pend)
            || overflow[e.ch] !== e.ovf) begin
          bad++;
          $display("FAIL %s ch%0d: got irq=%b pend=%0d ovf=%b, want irq=%b pend=%0d ovf=%b",
            e.tag, e.ch, irq[e.ch], pending[e.ch*CNT_W +: CNT_W], overflow[e.ch],
            e.irq, e.pend, e.ovf);
        end
      end
      req_raw[0] = (t == 2);
      rst = (t == 6);
    end
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); total++; bad++;
      $display("FAIL %s never reached", e.tag);
    end
  endtask

  task automatic test_debounce();
    exp_t e;
    int t;
    base = cyc;
    expect_at(25, 0, 1'b0, 0, 1'b0, "db_glitch1");
    expect_at(40, 0, 1'b0, 0, 1'b0, "db_glitch2");
    expect_at(58, 0, 1'b0, 0, 1'b0, "db_pre");
    expect_at(59, 0, 1'b1, 1, 1'b0, "db_rise");
    expect_at(62, 0, 1'b0, 0, 1'b0, "db_ack");
    expect_at(70, 0, 1'b0, 0, 1'b0, "db_once");
    expect_at(110, 0, 1'b0, 0, 1'b0, "db_fall");
    req_raw[0] = 1'b1;
    repeat (110) begin
      tick();
      t = cyc - base;
      while (sbq.size() > 0 && sbq[0].t <= cyc) begin
        e = sbq.pop_front();
        total++;
        if (irq[e.ch] !== e.irq || pending[e.ch*CNT_W +: CNT_W] !== CNT_W'(e.pend)
            || overflow[e.ch] !== e.ovf) begin
          bad++;
          $display("FAIL %s ch%0d: got irq=%b pend=%0d ovf=%b, want irq=%b pend=%0d ovf=%b",
            e.tag, e.ch, irq[e.ch], pending[e.ch*CNT_W +: CNT_W], overflow[e.ch],
            e.irq, e.pend, e.ovf);
        end
      end
      req_raw[0] = (t < 10) || (t >= 40 && t < 80);
      ack[0] = (t == 61);
    end
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); total++; bad++;
      $display("FAIL %s never reached", e.tag);
    end
  endtask

  initial begin
    test_reset();
`ifdef IRQ_DEBOUNCE_EN
    test_debounce();
`else
    test_single();
    test_multi();
    test_back_to_back();
    test_saturation();
    test_spurious();
    test_rst_mid();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
